// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder built from 1-bit full-adder cells; {carry,sum} = I0 + I1 + I2.
// Optional FULL_ADDER_STATS_EN adds carry_cnt, a saturating count of cycles that register carry=1.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             I2,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FULL_ADDER_STATS_EN
  ,
  output logic [15:0]      carry_cnt
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = I2;

  // Explicit cell chain: carry ripples combinationally through all WIDTH cells in one cycle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = I0[i] ^ I1[i] ^ c[i];
    assign c[i+1] = (I0[i] & I1[i]) | (c[i] & (I0[i] ^ I1[i]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= s;
      carry <= c[WIDTH];
    end
  end

`ifdef FULL_ADDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (c[WIDTH] && (carry_cnt != 16'hFFFF)) begin
      carry_cnt <= carry_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a WIDTH=1 and a WIDTH=8 instance checked against plain-arithmetic
// expectations, directed vectors plus $urandom traffic; stats counter checks when FULL_ADDER_STATS_EN is set.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] a1, b1;
  logic       c1;
  logic [7:0] a8, b8;
  logic       c8;
  logic [0:0] sum1;
  logic       carry1;
  logic [7:0] sum8;
  logic       carry8;
`ifdef FULL_ADDER_STATS_EN
  logic [15:0] cnt1, cnt8;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt1 = 0;
  int exp_cnt8 = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .I0(a1), .I1(b1), .I2(c1), .sum(sum1), .carry(carry1)
`ifdef FULL_ADDER_STATS_EN
    , .carry_cnt(cnt1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .I0(a8), .I1(b8), .I2(c8), .sum(sum8), .carry(carry8)
`ifdef FULL_ADDER_STATS_EN
    , .carry_cnt(cnt8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one edge worth of inputs, then check outputs just after that edge against arithmetic.
  task automatic apply(input logic rst, input logic x1, input logic y1, input logic z1,
                       input logic [7:0] x8, input logic [7:0] y8, input logic z8,
                       input string tag);
    int e1, e8;
    rst_n = rst; a1 = x1; b1 = y1; c1 = z1; a8 = x8; b8 = y8; c8 = z8;
    e1 = rst ? (int'(x1) + int'(y1) + int'(z1)) : 0;
    e8 = rst ? (int'(x8) + int'(y8) + int'(z8)) : 0;
    if (!rst) begin
      exp_cnt1 = 0;
      exp_cnt8 = 0;
    end else begin
      if (e1 >= 2   && exp_cnt1 < 65535) exp_cnt1++;
      if (e8 >= 256 && exp_cnt8 < 65535) exp_cnt8++;
    end
    @(posedge clk);
    #1;
    chk({tag, ".w1"}, {30'd0, carry1, sum1}, 32'(e1));
    chk({tag, ".w8"}, {23'd0, carry8, sum8}, 32'(e8));
`ifdef FULL_ADDER_STATS_EN
    chk({tag, ".cnt1"}, {16'd0, cnt1}, 32'(exp_cnt1));
    chk({tag, ".cnt8"}, {16'd0, cnt8}, 32'(exp_cnt8));
`endif
  endtask

  initial begin
    logic [2:0] v;
    logic [2:0] vecs [4];

    // Reset with all inputs high: outputs must stay zero.
    for (int i = 0; i < 2; i++) apply(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "reset");

    // Directed 1-bit vectors {I0,I1,I2}, each held for three cycles.
    vecs[0] = 3'b000; vecs[1] = 3'b011; vecs[2] = 3'b100; vecs[3] = 3'b111;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++)
        apply(1'b1, vecs[i][2], vecs[i][1], vecs[i][0], 8'h00, 8'h00, 1'b0, "hold");

    // All eight 1-bit combinations, with random traffic on the 8-bit instance.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      apply(1'b1, v[2], v[1], v[0], 8'($urandom), 8'($urandom), 1'($urandom), "all8");
    end

    // 8-bit boundary vectors.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, "ff_00_1");
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0, "5a_a5_0");
    apply(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, "ff_ff_1");

    for (int i = 0; i < 40; i++)
      apply(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom), "rand");

    // Single-edge reset mid-stream, then normal operation resumes immediately.
    apply(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h7F, 1'b1, "pre_rst");
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, "mid_rst");
    apply(1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1, "post_rst");
    apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0, "post_rst2");

`ifdef FULL_ADDER_STATS_EN
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "cnt_clr");
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, "cnt_run");
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "cnt_hold");
    chk("cnt_five", {16'd0, cnt1}, 32'd5);
    for (int i = 0; i < 65535; i++) apply(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, "cnt_sat");
    chk("cnt_sat_top", {16'd0, cnt1}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, "cnt_sat_hold");
    apply(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, "cnt_sat_rst");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
